// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter: FSM state codes,
// parity mode constants and the parity helper.
package uart_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    localparam int PAR_NONE = 32'sd0;
    localparam int PAR_EVEN = 32'sd1;
    localparam int PAR_ODD  = 32'sd2;

    // Zero-extended data leaves the XOR reduction unchanged, so 9 bits covers every legal DATA_W.
    function automatic logic calc_parity(input logic [8:0] data, input int mode);
        logic p;
        case (mode)
            PAR_EVEN: p = ^data;
            PAR_ODD:  p = ~^data;
            default:  p = 1'b0;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period divider: pulses baud_en on the last clock of each bit period
// while run is high, and holds its count at zero whenever run is low.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic baud_en
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count_r;

    // bit-period counter, wraps on the same edge that baud_en is seen
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_r <= CW'(0);
        end else if (!run) begin
            count_r <= CW'(0);
        end else if (count_r == CNT_MAX) begin
            count_r <= CW'(0);
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign baud_en = run && (count_r == CNT_MAX);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: valid/ready word input, LSB-first frame with
// start bit, optional parity and 1 or 2 stop bits, internal baud divider.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 434,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              txd,
    output logic              busy,
    output logic              baud_en
);

    localparam int IW = $clog2(DATA_W + 1);
    localparam logic [IW-1:0] LAST_DATA = IW'(DATA_W - 1);
    localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("uart_tx_param: DATA_W must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (CLKS_PER_BIT < 2) begin : g_bad_cpb
        $error("uart_tx_param: CLKS_PER_BIT must be at least 2");
    end

    state_t              state_r, next_state_s;
    logic [DATA_W-1:0]   shift_r, shift_nx_s;
    logic [IW-1:0]       bit_idx_r, bit_idx_nx_s;
    logic                parity_r;
    logic                accept_s, baud_s;
    logic                txd_r, ready_r, busy_r;
    logic                txd_nx_s, ready_nx_s, busy_nx_s;

    assign accept_s = (state_r == ST_IDLE) && tx_valid;

    uart_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .reset   (reset),
        .run     (busy_r),
        .baud_en (baud_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // FSM next-state logic; every transition out of a busy state waits for baud_en
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE:   if (accept_s) next_state_s = ST_START; else next_state_s = ST_IDLE;
            ST_START:  if (baud_s) next_state_s = ST_DATA; else next_state_s = ST_START;
            ST_DATA: begin
                if (baud_s && (bit_idx_r == LAST_DATA)) begin
                    next_state_s = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    next_state_s = ST_DATA;
                end
            end
            ST_PARITY: if (baud_s) next_state_s = ST_STOP; else next_state_s = ST_PARITY;
            ST_STOP: begin
                if (baud_s && (bit_idx_r == LAST_STOP)) next_state_s = ST_IDLE;
                else next_state_s = ST_STOP;
            end
            default:   next_state_s = ST_IDLE;
        endcase
    end

    // next shift register and bit index; index restarts on entry to DATA and STOP
    always_comb begin
        shift_nx_s   = shift_r;
        bit_idx_nx_s = bit_idx_r;
        if (accept_s) begin
            shift_nx_s   = tx_data;
            bit_idx_nx_s = IW'(0);
        end else if ((state_r == ST_DATA) && baud_s) begin
            shift_nx_s   = shift_r >> 1;
            bit_idx_nx_s = (next_state_s == ST_DATA) ? bit_idx_r + IW'(1) : IW'(0);
        end else if ((state_r == ST_STOP) && baud_s) begin
            shift_nx_s   = shift_r;
            bit_idx_nx_s = bit_idx_r + IW'(1);
        end else if ((state_r != ST_DATA) && (next_state_s == ST_DATA)) begin
            shift_nx_s   = shift_r;
            bit_idx_nx_s = IW'(0);
        end else begin
            shift_nx_s   = shift_r;
            bit_idx_nx_s = bit_idx_r;
        end
    end

    // output decode of the state being entered, so the outputs can be registered
    always_comb begin
        txd_nx_s   = 1'b1;
        ready_nx_s = 1'b0;
        busy_nx_s  = 1'b1;
        case (next_state_s)
            ST_IDLE: begin
                ready_nx_s = 1'b1;
                busy_nx_s  = 1'b0;
            end
            ST_START:  txd_nx_s = 1'b0;
            ST_DATA:   txd_nx_s = shift_nx_s[0];
            ST_PARITY: txd_nx_s = parity_r;
            ST_STOP:   txd_nx_s = 1'b1;
            default: begin
                txd_nx_s   = 1'b1;
                ready_nx_s = 1'b1;
                busy_nx_s  = 1'b0;
            end
        endcase
    end

    // datapath and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_r   <= DATA_W'(0);
            bit_idx_r <= IW'(0);
            parity_r  <= 1'b0;
            txd_r     <= 1'b1;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
        end else begin
            shift_r   <= shift_nx_s;
            bit_idx_r <= bit_idx_nx_s;
            if (accept_s) begin
                parity_r <= calc_parity(9'(tx_data), PARITY);
            end
            txd_r     <= txd_nx_s;
            ready_r   <= ready_nx_s;
            busy_r    <= busy_nx_s;
        end
    end

    assign txd      = txd_r;
    assign tx_ready = ready_r;
    assign busy     = busy_r;
    assign baud_en  = baud_s;

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboarded bench for uart_tx_param: five configurations share clock and
// reset; stimulus queues expected frames, one monitor per instance checks them.
module tb_uart_tx_param;

    localparam int N = 5;
    localparam int CPB  [N] = '{4, 4, 4, 4, 434};
    localparam int DW   [N] = '{8, 8, 8, 7, 8};
    localparam int PARM [N] = '{0, 1, 2, 0, 0};
    localparam int SB   [N] = '{1, 1, 1, 2, 1};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [N-1:0] valid = '0;
    logic [7:0]   data_v [N];
    logic [N-1:0] txd_v, ready_v, busy_v, ben_v;
    logic [N-1:0] mon_act = '0;
    logic [15:0]  exp_q [N][$];
    int           idle_pulses [N];
    int           vectors = 0;
    int           miscompares = 0;

    always #10 clk = ~clk;

    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .tx_valid(valid[0]), .tx_data(data_v[0]),
        .tx_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .baud_en(ben_v[0]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .tx_valid(valid[1]), .tx_data(data_v[1]),
        .tx_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .baud_en(ben_v[1]));
    uart_tx_param #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_valid(valid[2]), .tx_data(data_v[2]),
        .tx_ready(ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .baud_en(ben_v[2]));
    uart_tx_param #(.DATA_W(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .reset(reset), .tx_valid(valid[3]), .tx_data(data_v[3][6:0]),
        .tx_ready(ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .baud_en(ben_v[3]));
    uart_tx_param u_def (
        .clk(clk), .reset(reset), .tx_valid(valid[4]), .tx_data(data_v[4]),
        .tx_ready(ready_v[4]), .txd(txd_v[4]), .busy(busy_v[4]), .baud_en(ben_v[4]));

    // Monitors: every cycle of a frame is checked against the expected bit.
    for (genvar g = 0; g < N; g++) begin : g_mon
        initial begin : mon
            int k, b, nb, cpb, mism, bens, gap;
            logic [15:0] ent;
            logic [11:0] got;
            cpb = CPB[g];
            nb  = 1 + DW[g] + ((PARM[g] != 0) ? 1 : 0) + SB[g];
            k = 0; mism = 0; bens = 0; gap = 0; got = '0; ent = '0;
            idle_pulses[g] = 0;
            forever begin
                @(negedge clk);
                if (!busy_v[g] && ben_v[g]) idle_pulses[g]++;
                if (!reset) begin
                    mon_act[g] = 1'b0;
                    gap = 0;
                end else begin
                    if (!mon_act[g] && (txd_v[g] == 1'b0)) begin
                        if (exp_q[g].size() == 0) begin
                            miscompares++;
                            vectors++;
                            $display("FAIL unexpected_frame[%0d]: start bit seen, no frame queued", g);
                            ent = 16'h0000;
                        end else begin
                            ent = exp_q[g].pop_front();
                        end
                        if (ent[15]) begin
                            vectors++;
                            if (gap != 1) begin
                                miscompares++;
                                $display("FAIL gap[%0d]: %0d idle cycles, required 1", g, gap);
                            end
                        end
                        mon_act[g] = 1'b1;
                        k = 0; mism = 0; bens = 0; got = '0;
                    end
                    if (mon_act[g]) begin
                        if (k < nb * cpb) begin
                            b = k / cpb;
                            if (txd_v[g] !== ent[b]) mism++;
                            if (busy_v[g] !== 1'b1 || ready_v[g] !== 1'b0) mism++;
                            if (ben_v[g]) bens++;
                            if ((k % cpb) == (cpb / 2)) got[b] = txd_v[g];
                            k++;
                        end else begin
                            vectors++;
                            if (mism != 0 || got !== ent[11:0]) begin
                                miscompares++;
                                $display("FAIL frame[%0d]: got %b want %b (%0d bad cycles)",
                                         g, got, ent[11:0], mism);
                            end
                            vectors++;
                            if (bens != nb) begin
                                miscompares++;
                                $display("FAIL baud_count[%0d]: %0d pulses, required %0d", g, bens, nb);
                            end
                            vectors++;
                            if (txd_v[g] !== 1'b1 || ready_v[g] !== 1'b1 || busy_v[g] !== 1'b0) begin
                                miscompares++;
                                $display("FAIL end_idle[%0d]: txd/ready/busy %b%b%b, required 110",
                                         g, txd_v[g], ready_v[g], busy_v[g]);
                            end
                            mon_act[g] = 1'b0;
                            gap = 1;
                        end
                    end else begin
                        gap++;
                    end
                end
            end
        end
    end

    // Expected frame: bit 0 start, data LSB-first, hand-given parity, stop bits; bit 15 = back-to-back.
    task automatic push(input int g, input logic [7:0] d, input logic pbit, input logic bb);
        logic [15:0] e;
        int p;
        e = 16'h0000;
        p = 1;
        for (int i = 0; i < DW[g]; i++) begin e[p] = d[i]; p++; end
        if (PARM[g] != 0) begin e[p] = pbit; p++; end
        for (int i = 0; i < SB[g]; i++) begin e[p] = 1'b1; p++; end
        e[15] = bb;
        exp_q[g].push_back(e);
    endtask

    task automatic wait_accept(input int g);
        int t;
        t = 0;
        while (!ready_v[g] && t < 10000) begin @(negedge clk); t++; end
        vectors++;
        if (!ready_v[g]) begin
            miscompares++;
            $display("FAIL ready_timeout[%0d]: tx_ready %b, required 1", g, ready_v[g]);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int g, input logic [7:0] d, input logic pbit);
        push(g, d, pbit, 1'b0);
        data_v[g] = d;
        valid[g]  = 1'b1;
        wait_accept(g);
        valid[g]  = 1'b0;
        data_v[g] = ~d;
    endtask

    task automatic wait_done(input int g);
        int t;
        t = 0;
        while ((exp_q[g].size() != 0 || mon_act[g]) && t < 6000) begin
            @(negedge clk);
            #2;
            t++;
        end
        vectors++;
        if (exp_q[g].size() != 0 || mon_act[g]) begin
            miscompares++;
            $display("FAIL done_timeout[%0d]: %0d frames pending, required 0", g, exp_q[g].size());
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) data_v[i] = 8'h00;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            vectors++;
            if (txd_v !== 5'b11111 || ready_v !== 5'b11111 || busy_v !== 5'b00000 || ben_v !== 5'b00000) begin
                miscompares++;
                $display("FAIL reset_state: txd %b ready %b busy %b baud_en %b, required 11111 11111 00000 00000",
                         txd_v, ready_v, busy_v, ben_v);
            end
        end
        reset = 1'b1;
        @(negedge clk);

        send(0, 8'hA5, 1'b0); wait_done(0);
        send(0, 8'h3C, 1'b0); wait_done(0);
        send(1, 8'hAA, 1'b0); wait_done(1);
        send(1, 8'h07, 1'b1); wait_done(1);
        send(2, 8'h07, 1'b0);
        send(2, 8'h03, 1'b1); wait_done(2);

        // 7N2 back-to-back with tx_valid held and tx_data changed mid-frame
        push(3, 8'h55, 1'b0, 1'b0);
        data_v[3] = 8'h55;
        valid[3]  = 1'b1;
        wait_accept(3);
        repeat (10) @(negedge clk);
        data_v[3] = 8'h2A;
        push(3, 8'h2A, 1'b0, 1'b1);
        wait_accept(3);
        valid[3] = 1'b0;
        wait_done(3);

        // reset during data bit 3 of a 0xFF frame, then a clean frame
        send(0, 8'hFF, 1'b0);
        repeat (17) @(posedge clk);
        #3;
        vectors++;
        if (busy_v[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_busy: busy %b, required 1", busy_v[0]);
        end
        reset = 1'b0;
        #1;
        vectors++;
        if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || ready_v[0] !== 1'b1 || ben_v[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: txd %b busy %b ready %b baud_en %b, required 1 0 1 0",
                     txd_v[0], busy_v[0], ready_v[0], ben_v[0]);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        send(0, 8'h0F, 1'b0); wait_done(0);

        send(4, 8'h41, 1'b0); wait_done(4);

        for (int i = 0; i < N; i++) begin
            vectors++;
            if (idle_pulses[i] != 0) begin
                miscompares++;
                $display("FAIL idle_baud[%0d]: %0d pulses while idle, required 0", i, idle_pulses[i]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
